sys_div16: RTL and testbench
============================

Name: sys_div16

Overview:
- Register-based unsigned integer divider.
- Dividend and divisor are captured into separate operand registers under individual load enables.
- A third enable commits quotient and remainder of the stored operands into result registers.
- Sits on a simple register-mapped datapath. Outputs hold their value until the next commit or reset.

Parameters:
- WIDTH, 16, bit width of operands, quotient and remainder.

Ports:
- clk  input  1  system clock; all state updates on rising edge
- rst  input  1  synchronous reset, active-high
- d_a  input  WIDTH  dividend data, loaded when en_a=1
- d_b  input  WIDTH  divisor data, loaded when en_b=1
- en_a  input  1  load enable for dividend register
- en_b  input  1  load enable for divisor register
- en_result  input  1  commit enable for quotient/remainder registers
- quotient  output  WIDTH  registered quotient
- remainder  output  WIDTH  registered remainder

Behaviour:
- Internal state: reg_a, reg_b (operands) and reg_q, reg_r (results); all WIDTH bits, unsigned.
- Reset: on a rising edge with rst=1, all four registers become 0. Reset overrides every enable.
  - quotient=0 and remainder=0 are visible after that edge.
- en_a=1 at an edge: reg_a <= d_a. Otherwise reg_a holds.
- en_b=1 at an edge: reg_b <= d_b. Otherwise reg_b holds.
- en_result=1 at an edge, with reg_b != 0: reg_q <= reg_a / reg_b and reg_r <= reg_a % reg_b.
  - The operand values are those held before this edge.
- Divide by zero (reg_b == 0 at commit): reg_q <= all ones (65535) and reg_r <= reg_a. No X is ever produced.
- Simultaneous en_a/en_b with en_result at the same edge:
  - The result uses the old operand values.
  - The new operands are used only by a later commit.
  - This gives a two-cycle minimum from a new operand load to its result.
- en_result=0: reg_q and reg_r hold, regardless of operand loads or changes on d_a/d_b.
- Latency: results are visible on quotient/remainder immediately after the commit edge (1 cycle).
- quotient and remainder are driven directly from reg_q/reg_r; there is no combinational path from the inputs.
- Division is a combinational WIDTH-step restoring divider on reg_a/reg_b.
  - It completes within one clock period; no busy/valid handshake.
  - Invariant for reg_b != 0: reg_a == reg_q*reg_b + reg_r, with reg_r < reg_b.
- Full range 0..2^WIDTH-1 is supported; no overflow is possible for a nonzero divisor.

Decomposition:
- Shared package: WIDTH default constant and the divide-by-zero quotient constant (all ones).
- One natural sub-module, div_restoring_comb:
  - Purely combinational, parameterised by WIDTH.
  - Inputs dividend/divisor; outputs quotient/remainder.
  - Implements the divide-by-zero rule internally.
- The top level holds the four registers and the enable/reset logic.

Test Plan:
- Reset, then load 100 (en_a), then 50 (en_b), then en_result -> quotient=2, remainder=0. Check that the outputs stay 0 before the commit.
- Load 17/5 with en_a, en_b together, then en_result -> 3/2. Then load dividend 200 without en_result -> outputs stay 3/2. Then en_result -> 40/0.
- Boundaries:
  - 65535/65535 -> 1/0
  - 65535/256 -> 255/255
  - 5/10 -> 0/5
  - 12345/1 -> 12345/0
  - 65535/2 -> 32767/1
  - 1/1 -> 1/0
- Divide by zero: 100/0 commit -> quotient=65535, remainder=100, with no X on either output.
- Hold and reset:
  - Commit 789/12 -> 65/9.
  - Pulse rst -> 0/0 on the next edge.
  - Then 54321/123 -> 441/78.
  - Changing d_a/d_b with all enables low leaves the outputs unchanged.
- Same-edge load and commit:
  - With reg_a=100, reg_b=3 committed (33/1), assert en_a with d_a=200 together with en_result -> outputs 33/1.
  - Then en_result alone -> 66/2.
  - Also check 12345/67 -> 184/17.

Source files
------------

// File: rtl/sys_div16_pkg.sv
// Shared constants for the register-mapped unsigned divider.
//   DIV_WIDTH     : default operand/result width
//   DIV0_QUOTIENT : quotient committed when the stored divisor is zero
package sys_div16_pkg;

    localparam int unsigned DIV_WIDTH = 16;

    // Divide-by-zero quotient saturates to all ones; remainder passes the dividend.
    localparam logic [DIV_WIDTH-1:0] DIV0_QUOTIENT = '1;

    // True when the divisor would trigger the divide-by-zero rule.
    function automatic logic is_div_zero(input logic [DIV_WIDTH-1:0] divisor);
        return (divisor == '0);
    endfunction

endpackage

// File: rtl/sys_div16_div.sv
// Purely combinational WIDTH-step restoring divider.
//   dividend_i  : unsigned dividend
//   divisor_i   : unsigned divisor
//   quotient_o  : dividend_i / divisor_i, all ones when divisor_i == 0
//   remainder_o : dividend_i % divisor_i, dividend_i when divisor_i == 0
module div_restoring_comb #(
    parameter int unsigned WIDTH = 16
) (
    input  logic [WIDTH-1:0] dividend_i,
    input  logic [WIDTH-1:0] divisor_i,
    output logic [WIDTH-1:0] quotient_o,
    output logic [WIDTH-1:0] remainder_o
);

    logic [WIDTH-1:0] part_rem;
    logic [WIDTH-1:0] part_quo;
    logic [WIDTH-1:0] shift_a;
    logic [WIDTH:0]   trial;
    logic [WIDTH:0]   ext_div;
    logic             div_zero;

    assign div_zero = (divisor_i == '0);

    // One restoring step per dividend bit, MSB first. The trial value is one
    // bit wider than the remainder so the compare never overflows.
    always_comb begin
        part_rem = '0;
        part_quo = '0;
        shift_a  = dividend_i;
        trial    = '0;
        ext_div  = {1'b0, divisor_i};
        for (int unsigned s = 0; s < WIDTH; s++) begin
            trial   = {part_rem, shift_a[WIDTH-1]};
            shift_a = shift_a << 1;
            if (trial >= ext_div) begin
                part_rem = WIDTH'(trial - ext_div);
                part_quo = {part_quo[WIDTH-2:0], 1'b1};
            end else begin
                part_rem = WIDTH'(trial);
                part_quo = {part_quo[WIDTH-2:0], 1'b0};
            end
        end
    end

    // Explicit zero-divisor override keeps the result defined independent of
    // how the iteration happens to behave with a zero divisor.
    always_comb begin
        quotient_o  = part_quo;
        remainder_o = part_rem;
        if (div_zero) begin
            quotient_o  = '1;
            remainder_o = dividend_i;
        end
    end

endmodule

// File: rtl/sys_div16.sv
// Register-based unsigned divider.
//   clk        : system clock, rising edge
//   rst        : synchronous active-high reset, clears all four registers
//   d_a / en_a : dividend data / load enable
//   d_b / en_b : divisor data / load enable
//   en_result  : commit quotient/remainder of the currently stored operands
//   quotient   : registered quotient
//   remainder  : registered remainder
module sys_div16
    import sys_div16_pkg::*;
#(
    parameter int unsigned WIDTH = DIV_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] d_a,
    input  logic [WIDTH-1:0] d_b,
    input  logic             en_a,
    input  logic             en_b,
    input  logic             en_result,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder
);

    logic [WIDTH-1:0] reg_a_q, reg_a_d;
    logic [WIDTH-1:0] reg_b_q, reg_b_d;
    logic [WIDTH-1:0] reg_q_q, reg_q_d;
    logic [WIDTH-1:0] reg_r_q, reg_r_d;
    logic [WIDTH-1:0] div_quo;
    logic [WIDTH-1:0] div_rem;

    // Divider sees only the stored operands, so a same-edge load and commit
    // uses the old values and the new operands need a later commit.
    div_restoring_comb #(
        .WIDTH (WIDTH)
    ) u_div (
        .dividend_i  (reg_a_q),
        .divisor_i   (reg_b_q),
        .quotient_o  (div_quo),
        .remainder_o (div_rem)
    );

    // Next-state: independent enables, each register holds otherwise.
    always_comb begin
        reg_a_d = reg_a_q;
        reg_b_d = reg_b_q;
        reg_q_d = reg_q_q;
        reg_r_d = reg_r_q;
        if (en_a) begin
            reg_a_d = d_a;
        end
        if (en_b) begin
            reg_b_d = d_b;
        end
        if (en_result) begin
            reg_q_d = div_quo;
            reg_r_d = div_rem;
        end
    end

    // State registers; reset overrides every enable.
    always_ff @(posedge clk) begin
        if (rst) begin
            reg_a_q <= '0;
            reg_b_q <= '0;
            reg_q_q <= '0;
            reg_r_q <= '0;
        end else begin
            reg_a_q <= reg_a_d;
            reg_b_q <= reg_b_d;
            reg_q_q <= reg_q_d;
            reg_r_q <= reg_r_d;
        end
    end

    assign quotient  = reg_q_q;
    assign remainder = reg_r_q;

endmodule

// File: tb/tb_sys_div16.sv
// Directed self-checking bench for sys_div16.
module tb_sys_div16;

    logic        clk;
    logic        rst;
    logic [15:0] d_a;
    logic [15:0] d_b;
    logic        en_a;
    logic        en_b;
    logic        en_result;
    logic [15:0] quotient;
    logic [15:0] remainder;

    int checks;
    int failures;

    sys_div16 #(.WIDTH(16)) dut (
        .clk       (clk),
        .rst       (rst),
        .d_a       (d_a),
        .d_b       (d_b),
        .en_a      (en_a),
        .en_b      (en_b),
        .en_result (en_result),
        .quotient  (quotient),
        .remainder (remainder)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one edge and sample 1 time unit later.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        en_a = 1'b0; en_b = 1'b0; en_result = 1'b0; rst = 1'b0;
    endtask

    task automatic load_a(input logic [15:0] a);
        d_a = a; en_a = 1'b1; tick(); en_a = 1'b0;
    endtask

    task automatic load_b(input logic [15:0] b);
        d_b = b; en_b = 1'b1; tick(); en_b = 1'b0;
    endtask

    task automatic load_ab(input logic [15:0] a, input logic [15:0] b);
        d_a = a; d_b = b; en_a = 1'b1; en_b = 1'b1; tick();
        en_a = 1'b0; en_b = 1'b0;
    endtask

    task automatic commit();
        en_result = 1'b1; tick(); en_result = 1'b0;
    endtask

    task automatic test_reset();
        idle();
        d_a = 16'd0; d_b = 16'd0;
        rst = 1'b1; tick(); rst = 1'b0;
        checks++;
        if (quotient !== 16'd0 || remainder !== 16'd0) begin
            failures++;
            $display("FAIL reset: got %0d/%0d expected 0/0", quotient, remainder);
        end
    endtask

    task automatic test_basic();
        load_a(16'd100);
        load_b(16'd50);
        checks++;
        if (quotient !== 16'd0 || remainder !== 16'd0) begin
            failures++;
            $display("FAIL pre_commit_zero: got %0d/%0d expected 0/0", quotient, remainder);
        end
        commit();
        checks++;
        if (quotient !== 16'd2 || remainder !== 16'd0) begin
            failures++;
            $display("FAIL basic_100_50: got %0d/%0d expected 2/0", quotient, remainder);
        end
    endtask

    task automatic test_pair_load();
        load_ab(16'd17, 16'd5);
        commit();
        checks++;
        if (quotient !== 16'd3 || remainder !== 16'd2) begin
            failures++;
            $display("FAIL pair_17_5: got %0d/%0d expected 3/2", quotient, remainder);
        end
        load_a(16'd200);
        checks++;
        if (quotient !== 16'd3 || remainder !== 16'd2) begin
            failures++;
            $display("FAIL hold_after_load: got %0d/%0d expected 3/2", quotient, remainder);
        end
        commit();
        checks++;
        if (quotient !== 16'd40 || remainder !== 16'd0) begin
            failures++;
            $display("FAIL pair_200_5: got %0d/%0d expected 40/0", quotient, remainder);
        end
    endtask

    task automatic test_boundaries();
        logic [15:0] va [6] = '{16'd65535, 16'd65535, 16'd5,  16'd12345, 16'd65535, 16'd1};
        logic [15:0] vb [6] = '{16'd65535, 16'd256,   16'd10, 16'd1,     16'd2,     16'd1};
        logic [15:0] vq [6] = '{16'd1,     16'd255,   16'd0,  16'd12345, 16'd32767, 16'd1};
        logic [15:0] vr [6] = '{16'd0,     16'd255,   16'd5,  16'd0,     16'd1,     16'd0};
        for (int i = 0; i < 6; i++) begin
            load_ab(va[i], vb[i]);
            commit();
            checks++;
            if (quotient !== vq[i] || remainder !== vr[i]) begin
                failures++;
                $display("FAIL boundary_%0d (%0d/%0d): got %0d/%0d expected %0d/%0d",
                         i, va[i], vb[i], quotient, remainder, vq[i], vr[i]);
            end
        end
    endtask

    task automatic test_div_zero();
        load_ab(16'd100, 16'd0);
        commit();
        checks++;
        if (quotient !== 16'd65535 || remainder !== 16'd100 ||
            $isunknown({quotient, remainder})) begin
            failures++;
            $display("FAIL div_zero: got %0d/%0d expected 65535/100", quotient, remainder);
        end
    endtask

    task automatic test_hold_reset();
        load_ab(16'd789, 16'd12);
        commit();
        checks++;
        if (quotient !== 16'd65 || remainder !== 16'd9) begin
            failures++;
            $display("FAIL commit_789_12: got %0d/%0d expected 65/9", quotient, remainder);
        end
        // Reset must win over a concurrent commit.
        rst = 1'b1; en_result = 1'b1; tick(); rst = 1'b0; en_result = 1'b0;
        checks++;
        if (quotient !== 16'd0 || remainder !== 16'd0) begin
            failures++;
            $display("FAIL reset_pulse: got %0d/%0d expected 0/0", quotient, remainder);
        end
        // Operands were cleared too: a commit now is 0/0 -> divide by zero.
        commit();
        checks++;
        if (quotient !== 16'd65535 || remainder !== 16'd0) begin
            failures++;
            $display("FAIL reset_clears_operands: got %0d/%0d expected 65535/0", quotient, remainder);
        end
        load_ab(16'd54321, 16'd123);
        commit();
        checks++;
        if (quotient !== 16'd441 || remainder !== 16'd78) begin
            failures++;
            $display("FAIL commit_54321_123: got %0d/%0d expected 441/78", quotient, remainder);
        end
        d_a = 16'd7; d_b = 16'd3;
        tick(); tick();
        checks++;
        if (quotient !== 16'd441 || remainder !== 16'd78) begin
            failures++;
            $display("FAIL hold_no_enable: got %0d/%0d expected 441/78", quotient, remainder);
        end
    endtask

    task automatic test_same_edge();
        load_ab(16'd100, 16'd3);
        commit();
        checks++;
        if (quotient !== 16'd33 || remainder !== 16'd1) begin
            failures++;
            $display("FAIL same_edge_base: got %0d/%0d expected 33/1", quotient, remainder);
        end
        d_a = 16'd200; en_a = 1'b1; en_result = 1'b1; tick();
        en_a = 1'b0; en_result = 1'b0;
        checks++;
        if (quotient !== 16'd33 || remainder !== 16'd1) begin
            failures++;
            $display("FAIL same_edge_old_ops: got %0d/%0d expected 33/1", quotient, remainder);
        end
        commit();
        checks++;
        if (quotient !== 16'd66 || remainder !== 16'd2) begin
            failures++;
            $display("FAIL same_edge_new_ops: got %0d/%0d expected 66/2", quotient, remainder);
        end
        load_ab(16'd12345, 16'd67);
        commit();
        checks++;
        if (quotient !== 16'd184 || remainder !== 16'd17) begin
            failures++;
            $display("FAIL commit_12345_67: got %0d/%0d expected 184/17", quotient, remainder);
        end
    endtask

    task automatic test_back_to_back();
        // Consecutive commits of unchanged operands keep producing the same result.
        commit();
        commit();
        checks++;
        if (quotient !== 16'd184 || remainder !== 16'd17) begin
            failures++;
            $display("FAIL back_to_back: got %0d/%0d expected 184/17", quotient, remainder);
        end
        // Divisor-only reload followed by commit.
        load_b(16'd1000);
        commit();
        checks++;
        if (quotient !== 16'd12 || remainder !== 16'd345) begin
            failures++;
            $display("FAIL divisor_reload: got %0d/%0d expected 12/345", quotient, remainder);
        end
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        idle();
        d_a = '0;
        d_b = '0;
        test_reset();
        test_basic();
        test_pair_load();
        test_boundaries();
        test_div_zero();
        test_hold_reset();
        test_same_edge();
        test_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
